// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-wide registered RAM: issues byte-enabled word
// accesses, aligns store data, extends load data and splits word-crossing accesses in two.
module load_store_unit #(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic [1:0]  req_size,
   input  logic        req_unsign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, REQ0, DAT0, REQ1, DAT1, RESP} state_t;

   state_t state, state_nxt;

   // Request decode, only meaningful while IDLE.
   logic [7:0]  d_base, d_mask;
   logic [63:0] d_sdata;
   logic        d_split, d_err, accept;

   // Captured request and read words.
   logic        ld_q, uns_q, split_q;
   logic [1:0]  size_q, off_q;
   logic [29:0] w1_q;
   logic [3:0]  be1_q;
   logic [31:0] sdat1_q, r0_q, r1_q;

   // Load extraction.
   logic [31:0] lo, hi, ext;
   logic [63:0] shifted;

   // Next values of the registered outputs.
   logic        en_nxt, we_nxt, valid_nxt, err_nxt;
   logic [29:0] addr_nxt;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt, rdata_nxt;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;

   always_comb begin
      case (req_size)
         2'b00:   d_base = 8'h01;
         2'b01:   d_base = 8'h03;
         default: d_base = 8'h0F;
      endcase
      d_mask  = d_base << req_addr[1:0];
      d_split = |d_mask[7:4];
      d_err   = (req_size == 2'b11) || (d_split && !ALLOW_MISALIGNED);
      d_sdata = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
   end

   // The word arriving this cycle is used directly so the response is ready on RESP entry.
   always_comb begin
      lo      = (state == DAT0) ? mem_rdata : r0_q;
      hi      = (state == DAT1) ? mem_rdata : r1_q;
      shifted = {hi, lo} >> {off_q, 3'b000};
      case (size_q)
         2'b00:   ext = {{24{!uns_q && shifted[7]}}, shifted[7:0]};
         2'b01:   ext = {{16{!uns_q && shifted[15]}}, shifted[15:0]};
         default: ext = shifted[31:0];
      endcase
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = d_err ? RESP : REQ0;
         REQ0: state_nxt = ld_q ? DAT0 : (split_q ? REQ1 : RESP);
         DAT0: state_nxt = split_q ? REQ1 : RESP;
         REQ1: state_nxt = ld_q ? DAT1 : RESP;
         DAT1: state_nxt = RESP;
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      en_nxt    = 1'b0;
      we_nxt    = 1'b0;
      be_nxt    = 4'b0;
      addr_nxt  = mem_addr;
      wdata_nxt = mem_wdata;
      if (state_nxt == REQ0) begin
         en_nxt    = 1'b1;
         we_nxt    = !req_load;
         be_nxt    = d_mask[3:0];
         addr_nxt  = req_addr[31:2];
         wdata_nxt = d_sdata[31:0];
      end else if (state_nxt == REQ1) begin
         en_nxt    = 1'b1;
         we_nxt    = !ld_q;
         be_nxt    = be1_q;
         addr_nxt  = w1_q;
         wdata_nxt = sdat1_q;
      end

      valid_nxt = (state_nxt == RESP);
      err_nxt   = valid_nxt && ((state == IDLE) ? d_err : rsp_err);
      rdata_nxt = 32'b0;
      if (valid_nxt) begin
         if (state == RESP)                                rdata_nxt = rsp_rdata;
         else if (ld_q && (state == DAT0 || state == DAT1)) rdata_nxt = ext;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= 4'b0;
         mem_addr  <= 30'b0;
         mem_wdata <= 32'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'b0;
      end else begin
         state     <= state_nxt;
         mem_en    <= en_nxt;
         mem_we    <= we_nxt;
         mem_be    <= be_nxt;
         mem_addr  <= addr_nxt;
         mem_wdata <= wdata_nxt;
         rsp_valid <= valid_nxt;
         rsp_err   <= err_nxt;
         rsp_rdata <= rdata_nxt;
      end
   end

   // NOTE: pure datapath registers carry no reset; the FSM never consumes them before a capture.
   always_ff @(posedge clk) begin
      if (accept) begin
         ld_q    <= req_load;
         uns_q   <= req_unsign;
         size_q  <= req_size;
         off_q   <= req_addr[1:0];
         split_q <= d_split;
         w1_q    <= req_addr[31:2] + 30'd1;
         be1_q   <= d_mask[7:4];
         sdat1_q <= d_sdata[63:32];
      end
      if (state == DAT0) r0_q <= mem_rdata;
      if (state == DAT1) r1_q <= mem_rdata;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expected memory accesses and responses,
// independent monitors pop and compare them as the DUT presents them.
module tb_load_store_unit;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          cap;
   } rsp_t;

   typedef struct packed {
      logic [29:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } acc_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid, req_ready, req_load, req_unsign, rsp_valid, rsp_ready, rsp_err;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, rsp_rdata, mem_wdata, mem_rdata;
   logic        mem_en, mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;

   logic        req_valid_na, req_ready_na, req_load_na, req_unsign_na, rsp_valid_na, rsp_ready_na;
   logic        rsp_err_na, mem_en_na, mem_we_na;
   logic [1:0]  req_size_na;
   logic [31:0] req_addr_na, req_wdata_na, rsp_rdata_na, mem_wdata_na;
   logic [31:0] mem_rdata_na = 32'h0;
   logic [29:0] mem_addr_na;
   logic [3:0]  mem_be_na;

   load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_size(req_size),
      .req_unsign(req_unsign), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_na (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid_na), .req_ready(req_ready_na), .req_load(req_load_na),
      .req_size(req_size_na), .req_unsign(req_unsign_na), .req_addr(req_addr_na),
      .req_wdata(req_wdata_na),
      .rsp_valid(rsp_valid_na), .rsp_ready(rsp_ready_na), .rsp_rdata(rsp_rdata_na),
      .rsp_err(rsp_err_na),
      .mem_en(mem_en_na), .mem_we(mem_we_na), .mem_addr(mem_addr_na), .mem_be(mem_be_na),
      .mem_wdata(mem_wdata_na), .mem_rdata(mem_rdata_na)
   );

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   na_acc = 0;
   rsp_t rq[$];
   acc_t aq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Registered RAM model, 256 words indexed by the low word-address bits.
   logic [31:0] ram [0:255];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int i = 0; i < 4; i++)
               if (mem_be[i]) ram[mem_addr[7:0]][8*i +: 8] <= mem_wdata[8*i +: 8];
         end else begin
            mem_rdata <= ram[mem_addr[7:0]];
         end
      end
   end

   // Memory access monitor.
   acc_t a;
   always @(negedge clk) begin
      if (mem_en) begin
         if (aq.size() == 0) fail("unexpected_mem_access");
         else begin
            a = aq.pop_front();
            check("mem_addr", 64'(mem_addr), 64'(a.addr));
            check("mem_we", 64'(mem_we), 64'(a.we));
            if (a.we) begin
               check("mem_be", 64'(mem_be), 64'(a.be));
               check("mem_wdata", 64'(mem_wdata & lane_mask(a.be)), 64'(a.wdata));
            end
         end
      end
      if (mem_en_na) na_acc++;
   end

   // Response monitor: compares the first cycle of each response, then stability while held.
   logic        prev_valid = 1'b0;
   logic [31:0] held;
   rsp_t        e;
   always @(negedge clk) begin
      if (rsp_valid && !prev_valid) begin
         if (rq.size() == 0) fail("unexpected_rsp");
         else begin
            e = rq.pop_front();
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            check("latency", 64'(cyc - e.cap + 1), 64'(e.lat));
            held = e.rdata;
         end
      end else if (rsp_valid) begin
         check("hold_rdata", 64'(rsp_rdata), 64'(held));
         check("hold_req_ready", 64'(req_ready), 64'(0));
         check("hold_mem_en", 64'(mem_en), 64'(0));
      end
      prev_valid = rsp_valid;
   end

   task automatic exp_acc(input logic [29:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wd);
      aq.push_back('{addr: addr, we: we, be: be, wdata: wd});
   endtask

   task automatic issue(input logic ld, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int el, input bit want);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         fail("req_ready_timeout");
         return;
      end
      #1;
      req_valid  = 1'b1;
      req_load   = ld;
      req_size   = sz;
      req_unsign = uns;
      req_addr   = addr;
      req_wdata  = wd;
      if (want) rq.push_back('{rdata: er, err: ee, lat: el, cap: cyc + 1});
      @(negedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((rq.size() != 0 || !req_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (rq.size() != 0 || !req_ready) fail("drain_timeout");
   endtask

   task automatic issue_na(input logic [1:0] sz, input logic [31:0] addr);
      @(negedge clk);
      #1;
      req_valid_na  = 1'b1;
      req_load_na   = 1'b1;
      req_size_na   = sz;
      req_addr_na   = addr;
      @(negedge clk);
      check("na_rsp_valid", 64'(rsp_valid_na), 64'(1));
      check("na_rsp_err", 64'(rsp_err_na), 64'(1));
      check("na_rsp_rdata", 64'(rsp_rdata_na), 64'(0));
      #1 req_valid_na = 1'b0;
      @(negedge clk);
      check("na_rsp_done", 64'(rsp_valid_na), 64'(0));
   endtask

   initial begin
      req_valid = 0; req_load = 0; req_size = 0; req_unsign = 0; req_addr = 0; req_wdata = 0;
      rsp_ready = 1;
      req_valid_na = 0; req_load_na = 0; req_size_na = 0; req_unsign_na = 0;
      req_addr_na = 0; req_wdata_na = 0; rsp_ready_na = 1;
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      ram[8'h40] = 32'h80332211;
      ram[8'h41] = 32'h88776655;
      ram[8'hFF] = 32'hAB000000;
      ram[8'h00] = 32'h000000CD;

      repeat (3) @(negedge clk);
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_err", 64'(rsp_err), 64'(0));
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      check("rst_mem_en", 64'(mem_en), 64'(0));
      check("rst_mem_we", 64'(mem_we), 64'(0));
      check("rst_mem_be", 64'(mem_be), 64'(0));
      check("rst_req_ready", 64'(req_ready), 64'(1));
      #1 rst_n = 1'b1;

      // Aligned loads from word 0x40 = 0x80332211.
      exp_acc(30'h40, 0, 0, 0); issue(1, 2'b00, 0, 32'h103, 0, 32'hFFFFFF80, 0, 3, 1); wait_idle();
      exp_acc(30'h40, 0, 0, 0); issue(1, 2'b00, 1, 32'h103, 0, 32'h00000080, 0, 3, 1); wait_idle();
      exp_acc(30'h40, 0, 0, 0); issue(1, 2'b01, 0, 32'h102, 0, 32'hFFFF8033, 0, 3, 1); wait_idle();
      exp_acc(30'h40, 0, 0, 0); issue(1, 2'b01, 1, 32'h100, 0, 32'h00002211, 0, 3, 1); wait_idle();
      exp_acc(30'h40, 0, 0, 0); issue(1, 2'b10, 0, 32'h100, 0, 32'h80332211, 0, 3, 1); wait_idle();

      // Aligned word store, then split word load across 0x100/0x104.
      exp_acc(30'h40, 1, 4'b1111, 32'h44332211);
      issue(0, 2'b10, 0, 32'h100, 32'h44332211, 0, 0, 2, 1); wait_idle();
      exp_acc(30'h40, 0, 0, 0); exp_acc(30'h41, 0, 0, 0);
      issue(1, 2'b10, 0, 32'h102, 0, 32'h66554433, 0, 5, 1); wait_idle();

      // Split half store 0xBEEF at 0x103, then read it back both ways.
      exp_acc(30'h40, 1, 4'b1000, 32'hEF000000); exp_acc(30'h41, 1, 4'b0001, 32'h000000BE);
      issue(0, 2'b01, 0, 32'h103, 32'h0000BEEF, 0, 0, 3, 1); wait_idle();
      exp_acc(30'h40, 0, 0, 0); exp_acc(30'h41, 0, 0, 0);
      issue(1, 2'b01, 1, 32'h103, 0, 32'h0000BEEF, 0, 5, 1); wait_idle();

      // Response held off for 5 cycles.
      rsp_ready = 1'b0;
      exp_acc(30'h40, 0, 0, 0); exp_acc(30'h41, 0, 0, 0);
      issue(1, 2'b01, 0, 32'h103, 0, 32'hFFFFBEEF, 0, 5, 1);
      for (int n = 0; n < 50 && !rsp_valid; n++) @(negedge clk);
      if (!rsp_valid) fail("hold_rsp_timeout");
      repeat (5) @(negedge clk);
      #1 rsp_ready = 1'b1;
      wait_idle();

      // Illegal size: error after one cycle, no memory access.
      issue(1, 2'b11, 0, 32'h100, 0, 32'h0, 1, 1, 1); wait_idle();

      // Byte store with junk upper data, then read back.
      exp_acc(30'h40, 1, 4'b0010, 32'h00005A00);
      issue(0, 2'b00, 0, 32'h101, 32'h1234565A, 0, 0, 2, 1); wait_idle();
      exp_acc(30'h40, 0, 0, 0); issue(1, 2'b00, 1, 32'h101, 0, 32'h0000005A, 0, 3, 1); wait_idle();

      // Split word store at 0x101 and round-trip load.
      exp_acc(30'h40, 1, 4'b1110, 32'hCCBBAA00); exp_acc(30'h41, 1, 4'b0001, 32'h000000DD);
      issue(0, 2'b10, 0, 32'h101, 32'hDDCCBBAA, 0, 0, 3, 1); wait_idle();
      exp_acc(30'h40, 0, 0, 0); exp_acc(30'h41, 0, 0, 0);
      issue(1, 2'b10, 0, 32'h101, 0, 32'hDDCCBBAA, 0, 5, 1); wait_idle();

      // Split half at the top of the address space wraps to word 0.
      exp_acc(30'h3FFFFFFF, 0, 0, 0); exp_acc(30'h0, 0, 0, 0);
      issue(1, 2'b01, 1, 32'hFFFFFFFF, 0, 32'h0000CDAB, 0, 5, 1); wait_idle();

      // Reset during DAT0 of a split load: only the first read happens, no response.
      exp_acc(30'h40, 0, 0, 0);
      issue(1, 2'b10, 0, 32'h102, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
      check("abort_req_ready", 64'(req_ready), 64'(1));
      check("abort_mem_en", 64'(mem_en), 64'(0));
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      exp_acc(30'h41, 0, 0, 0); issue(1, 2'b10, 0, 32'h104, 0, 32'h887766DD, 0, 3, 1); wait_idle();

      // Misalignment rejected when splitting is disabled, plus illegal size.
      issue_na(2'b10, 32'h101);
      issue_na(2'b11, 32'h100);

      repeat (5) @(negedge clk);
      check("rsp_queue_empty", 64'(rq.size()), 64'(0));
      check("acc_queue_empty", 64'(aq.size()), 64'(0));
      check("na_no_mem_access", 64'(na_acc), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
